// File: rtl/uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler
//
// Purpose: UART receive stage fed by the UART clock generator's sampling
// clock (SAMPLES_PER_BIT ticks per bit). The module does the following:
//   - synchronises the serial line and the sampling clock,
//   - majority-votes three mid-bit samples,
//   - de-frames start / 8 data / optional parity / stop,
//   - holds the received byte for the core with a valid/read handshake.
//
// Ports:
//   physical_clock     in   system clock, all state on rising edge
//   init_flag          in   asynchronous active-low reset
//   sampling_clock_in  in   sampling clock from generator, treated as data
//   rx_serial          in   UART line, idle high
//   rx_read            in   1-cycle pulse: core consumes held byte
//   rx_data            out  last received byte (LSB first on the line)
//   rx_valid           out  rx_data holds an unread byte
//   parity_error       out  parity mismatch on byte in rx_data
//   framing_error      out  stop bit sampled low on byte in rx_data
//   overrun            out  sticky: a byte completed while rx_valid was set
//   rx_busy            out  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_oversampler #(
  parameter int SAMPLES_PER_BIT = 10,
  parameter int PARITY_EN       = 1,
  parameter int PARITY_ODD      = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       physical_clock,
  input  logic       init_flag,
  input  logic       sampling_clock_in,
  input  logic       rx_serial,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam int MID   = SAMPLES_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_COMPLETE = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronisers reset to 1 so a reset looks like an idle line and does
  // not produce a spurious sample tick on release.
  logic [SYNC_STAGES-1:0] rx_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic                   sclk_prev_q;

  always_ff @(posedge physical_clock or negedge init_flag) begin
    if (!init_flag) begin
      rx_sync_q   <= '1;
      sclk_sync_q <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      rx_sync_q[0]   <= rx_serial;
      sclk_sync_q[0] <= sampling_clock_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rx_sync_q[i]   <= rx_sync_q[i-1];
        sclk_sync_q[i] <= sclk_sync_q[i-1];
      end
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic rx_s;
  logic sample_tick;

  assign rx_s        = rx_sync_q[SYNC_STAGES-1];
  assign sample_tick = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;

  // Receiver state and datapath registers
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       smp_q, smp_d;
  logic             par_bit_q, par_bit_d;
  logic             stop_vote_q, stop_vote_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             overrun_q, overrun_d;

  logic at_wrap;
  logic bit_vote;
  logic stop_vote_now;
  logic perr_calc;

  assign at_wrap  = (cnt_q == CNT_LAST);
  assign bit_vote = maj3(smp_q[0], smp_q[1], smp_q[2]);
  // The stop bit is decided on its third voted sample, which is the live
  // line value, so the receiver can rearm before the stop bit ends.
  assign stop_vote_now = maj3(smp_q[0], smp_q[1], rx_s);
  assign perr_calc = (PARITY_EN != 0) ?
                     (^shift_q ^ par_bit_q ^ (PARITY_ODD != 0)) : 1'b0;

  // State register
  always_ff @(posedge physical_clock or negedge init_flag) begin
    if (!init_flag) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (sample_tick && at_wrap) state_d = bit_vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_tick && at_wrap && (bit_idx_q == 3'd7)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample_tick && at_wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_tick && (cnt_q == CNT_HI)) state_d = ST_COMPLETE;
      end
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: counters, vote samples, shift register, holding
  // register and handshake flags.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    smp_d       = smp_q;
    par_bit_d   = par_bit_q;
    stop_vote_d = stop_vote_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    overrun_d   = overrun_q;

    if (sample_tick) begin
      if (state_q == ST_IDLE) begin
        // The tick that detects the low line is sample 0 of the start bit.
        if (!rx_s) begin
          cnt_d     = CNT_ONE;
          bit_idx_d = 3'd0;
        end
      end else if (state_q != ST_COMPLETE) begin
        if (cnt_q == CNT_LO)  smp_d[0] = rx_s;
        if (cnt_q == CNT_MID) smp_d[1] = rx_s;
        if (cnt_q == CNT_HI)  smp_d[2] = rx_s;
        cnt_d = at_wrap ? '0 : cnt_q + CNT_ONE;

        case (state_q)
          ST_DATA: begin
            if (at_wrap) begin
              shift_d[bit_idx_q] = bit_vote;
              bit_idx_d          = bit_idx_q + 3'd1;
            end
          end
          ST_PARITY: begin
            if (at_wrap) par_bit_d = bit_vote;
          end
          ST_STOP: begin
            if (cnt_q == CNT_HI) begin
              stop_vote_d = stop_vote_now;
              cnt_d       = '0;
            end
          end
          default: ;
        endcase
      end
    end

    if (rx_read && rx_valid_q) begin
      rx_valid_d = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
    end

    // A completing byte always wins over a same-cycle read; it counts as
    // an overrun only if the previous byte was left unread.
    if (state_q == ST_COMPLETE) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      perr_d     = perr_calc;
      ferr_d     = ~stop_vote_q;
      if (rx_valid_q && !rx_read) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge physical_clock or negedge init_flag) begin
    if (!init_flag) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      smp_q       <= '0;
      par_bit_q   <= 1'b0;
      stop_vote_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      smp_q       <= smp_d;
      par_bit_q   <= par_bit_d;
      stop_vote_q <= stop_vote_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs
  always_comb begin
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    parity_error  = perr_q;
    framing_error = ferr_q;
    overrun       = overrun_q;
    rx_busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
module tb_uart_rx_oversampler;

  logic       physical_clock;
  logic       init_flag;
  logic       sampling_clock_in;
  logic       rx_serial;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  uart_rx_oversampler #(
    .SAMPLES_PER_BIT(10),
    .PARITY_EN(1),
    .PARITY_ODD(0),
    .SYNC_STAGES(2)
  ) dut (
    .physical_clock   (physical_clock),
    .init_flag        (init_flag),
    .sampling_clock_in(sampling_clock_in),
    .rx_serial        (rx_serial),
    .rx_read          (rx_read),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .parity_error     (parity_error),
    .framing_error    (framing_error),
    .overrun          (overrun),
    .rx_busy          (rx_busy)
  );

  initial begin
    physical_clock = 1'b0;
    forever #5 physical_clock = ~physical_clock;
  end

  // Sampling clock: period 10 system clocks
  initial begin
    sampling_clock_in = 1'b0;
    forever begin
      repeat (5) @(negedge physical_clock);
      sampling_clock_in = ~sampling_clock_in;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge physical_clock);
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (100) @(negedge physical_clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic read_pulse();
    @(negedge physical_clock);
    rx_read = 1'b1;
    @(negedge physical_clock);
    rx_read = 1'b0;
  endtask

  initial begin
    // data, parity bit, stop bit, expected parity_error, expected framing_error
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};

    init_flag = 1'b0;
    rx_serial = 1'b1;
    rx_read   = 1'b0;
    idle(5);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_parity_error", {31'd0, parity_error}, 32'd0);
    chk("reset_framing_error", {31'd0, framing_error}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    init_flag = 1'b1;
    idle(50);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      idle(150);
      chk($sformatf("vec%0d_valid", v), {31'd0, rx_valid}, 32'd1);
      chk($sformatf("vec%0d_data", v), {24'd0, rx_data}, {24'd0, vecs[v].data});
      chk($sformatf("vec%0d_perr", v), {31'd0, parity_error}, {31'd0, vecs[v].exp_perr});
      chk($sformatf("vec%0d_ferr", v), {31'd0, framing_error}, {31'd0, vecs[v].exp_ferr});
      chk($sformatf("vec%0d_overrun", v), {31'd0, overrun}, 32'd0);
      chk($sformatf("vec%0d_busy", v), {31'd0, rx_busy}, 32'd0);
      read_pulse();
      chk($sformatf("vec%0d_valid_after_read", v), {31'd0, rx_valid}, 32'd0);
      chk($sformatf("vec%0d_perr_after_read", v), {31'd0, parity_error}, 32'd0);
      chk($sformatf("vec%0d_ferr_after_read", v), {31'd0, framing_error}, 32'd0);
      chk($sformatf("vec%0d_data_held", v), {24'd0, rx_data}, {24'd0, vecs[v].data});
      idle(20);
    end

    // False start: short low pulse
    rx_serial = 1'b0;
    idle(30);
    rx_serial = 1'b1;
    idle(20);
    chk("false_start_busy", {31'd0, rx_busy}, 32'd1);
    idle(150);
    chk("false_start_idle", {31'd0, rx_busy}, 32'd0);
    chk("false_start_valid", {31'd0, rx_valid}, 32'd0);

    // Overrun: two frames with no read between them
    send_frame(8'h11, 1'b0, 1'b1);
    idle(50);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(150);
    chk("overrun_data", {24'd0, rx_data}, 32'h22);
    chk("overrun_valid", {31'd0, rx_valid}, 32'd1);
    chk("overrun_flag", {31'd0, overrun}, 32'd1);
    read_pulse();
    chk("overrun_valid_after_read", {31'd0, rx_valid}, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    idle(50);

    // Reset midway through data bit 4 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_serial = 1'b1;
    idle(50);
    chk("midframe_busy", {31'd0, rx_busy}, 32'd1);
    init_flag = 1'b0;
    #1;
    chk("midreset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("midreset_valid", {31'd0, rx_valid}, 32'd0);
    chk("midreset_overrun", {31'd0, overrun}, 32'd0);
    chk("midreset_busy", {31'd0, rx_busy}, 32'd0);
    chk("midreset_perr", {31'd0, parity_error}, 32'd0);
    chk("midreset_ferr", {31'd0, framing_error}, 32'd0);
    idle(20);
    init_flag = 1'b1;
    idle(100);
    chk("postreset_valid", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(150);
    chk("postreset_valid_frame", {31'd0, rx_valid}, 32'd1);
    chk("postreset_data", {24'd0, rx_data}, 32'h0F);
    chk("postreset_perr", {31'd0, parity_error}, 32'd0);
    chk("postreset_ferr", {31'd0, framing_error}, 32'd0);
    chk("postreset_overrun", {31'd0, overrun}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
